// File: rtl/s_axi_mem_pkg.sv
// s_axi_mem_pkg: bus widths, response codes,
// FSM state types and address helpers.
package s_axi_mem_pkg;

  localparam int DWIDTH       = 32;
  localparam int MEM_WIDTH    = 32;
  localparam int ID_WIDTH     = 1;
  localparam int AWUSER_WIDTH = 1;
  localparam int WUSER_WIDTH  = 1;
  localparam int BUSER_WIDTH  = 1;
  localparam int ARUSER_WIDTH = 1;
  localparam int RUSER_WIDTH  = 1;
  localparam int STRB_W       = DWIDTH / 8;

  function automatic int clogb2(input int v);
    int r;
    int x;
    r = 0;
    x = v;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

  localparam int ASZ = clogb2(STRB_W - 1);

  localparam logic [1:0] OKAY       = 2'b00;
  localparam logic [1:0] SLVERR     = 2'b10;
  localparam logic [1:0] BURST_INCR = 2'b01;

  typedef enum logic [1:0] {
    S_W_IDLE,
    S_W_DATA,
    S_W_RESP
  } w_state_e;

  typedef enum logic [1:0] {
    S_R_IDLE,
    S_R_FETCH,
    S_R_DATA
  } r_state_e;

  // Only full-width INCR bursts are served.
  function automatic logic bad_burst(
    input logic [1:0] burst,
    input logic [2:0] size
  );
    return (burst != BURST_INCR) ||
           (size != 3'(ASZ));
  endfunction

endpackage

// File: rtl/s_axi_mem_if.sv
// s_axi_mem_if: AXI4 full channel bundle.
// master drives requests, slave drives responses.
interface s_axi_mem_if;
  import s_axi_mem_pkg::*;

  logic                    awvalid;
  logic                    awready;
  logic [ID_WIDTH-1:0]     awid;
  logic [MEM_WIDTH-1:0]    awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awlock;
  logic [3:0]              awcache;
  logic [2:0]              awprot;
  logic [3:0]              awqos;
  logic [AWUSER_WIDTH-1:0] awuser;

  logic                    wvalid;
  logic                    wready;
  logic [DWIDTH-1:0]       wdata;
  logic [STRB_W-1:0]       wstrb;
  logic                    wlast;
  logic [WUSER_WIDTH-1:0]  wuser;

  logic                    bvalid;
  logic                    bready;
  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic [BUSER_WIDTH-1:0]  buser;

  logic                    arvalid;
  logic                    arready;
  logic [ID_WIDTH-1:0]     arid;
  logic [MEM_WIDTH-1:0]    araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arlock;
  logic [3:0]              arcache;
  logic [2:0]              arprot;
  logic [3:0]              arqos;
  logic [ARUSER_WIDTH-1:0] aruser;

  logic                    rvalid;
  logic                    rready;
  logic [ID_WIDTH-1:0]     rid;
  logic [DWIDTH-1:0]       rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic [RUSER_WIDTH-1:0]  ruser;

  modport slave (
    input  awvalid, awid, awaddr, awlen,
           awsize, awburst, awlock, awcache,
           awprot, awqos, awuser,
    output awready,
    input  wvalid, wdata, wstrb, wlast, wuser,
    output wready,
    output bvalid, bid, bresp, buser,
    input  bready,
    input  arvalid, arid, araddr, arlen,
           arsize, arburst, arlock, arcache,
           arprot, arqos, aruser,
    output arready,
    output rvalid, rid, rdata, rresp,
           rlast, ruser,
    input  rready
  );

  modport master (
    output awvalid, awid, awaddr, awlen,
           awsize, awburst, awlock, awcache,
           awprot, awqos, awuser,
    input  awready,
    output wvalid, wdata, wstrb, wlast, wuser,
    input  wready,
    input  bvalid, bid, bresp, buser,
    output bready,
    output arvalid, arid, araddr, arlen,
           arsize, arburst, arlock, arcache,
           arprot, arqos, aruser,
    input  arready,
    input  rvalid, rid, rdata, rresp,
           rlast, ruser,
    output rready
  );

endinterface

// File: rtl/s_axi_mem_mem_dp.sv
// s_axi_mem_mem_dp: simple dual-port RAM, byte-enable
// write port, registered read port with enable.
module s_axi_mem_mem_dp #(
  parameter int DW = 32,
  parameter int AW = 10
) (
  input  logic            clk,
  input  logic            we,
  input  logic [DW/8-1:0] be,
  input  logic [AW-1:0]   waddr,
  input  logic [DW-1:0]   wdata,
  input  logic            re,
  input  logic [AW-1:0]   raddr,
  output logic [DW-1:0]   rdata
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  // Read output holds while re=0, which keeps
  // a stalled beat stable.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < DW/8; i++) begin
        if (be[i]) begin
          mem_q[waddr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
    if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/s_axi_mem.sv
// s_axi_mem: AXI4 INCR-burst slave over on-chip RAM.
// Ports: clk, xrst (async, active low), axi slave.
module s_axi_mem
  import s_axi_mem_pkg::*;
#(
  parameter int DEPTH_LOG = 10
) (
  input  logic        clk,
  input  logic        xrst,
  s_axi_mem_if.slave  axi
);

  typedef logic [DEPTH_LOG-1:0] idx_t;
  localparam int IHI = DEPTH_LOG + ASZ - 1;

  w_state_e            w_state_q, w_state_d;
  logic [ID_WIDTH-1:0] wid_q, wid_d;
  idx_t                widx_q, widx_d;
  logic [7:0]          wlen_q, wlen_d;
  logic [7:0]          wbeat_q, wbeat_d;
  logic                werr_b_q, werr_b_d;
  logic                werr_l_q, werr_l_d;

  r_state_e            r_state_q, r_state_d;
  logic [ID_WIDTH-1:0] rid_q, rid_d;
  idx_t                ridx_q, ridx_d;
  logic [7:0]          rlen_q, rlen_d;
  logic [7:0]          rbeat_q, rbeat_d;
  logic                rerr_q, rerr_d;

  logic                mem_we;
  logic                mem_re;
  logic [DWIDTH-1:0]   mem_rdata;

  always_comb begin
    w_state_d = w_state_q;
    wid_d     = wid_q;
    widx_d    = widx_q;
    wlen_d    = wlen_q;
    wbeat_d   = wbeat_q;
    werr_b_d  = werr_b_q;
    werr_l_d  = werr_l_q;
    mem_we    = 1'b0;
    unique case (w_state_q)
      S_W_IDLE: begin
        if (axi.awvalid) begin
          w_state_d = S_W_DATA;
          wid_d     = axi.awid;
          widx_d    = axi.awaddr[IHI:ASZ];
          wlen_d    = axi.awlen;
          wbeat_d   = 8'd0;
          werr_b_d  = bad_burst(axi.awburst,
                                axi.awsize);
          werr_l_d  = 1'b0;
        end
      end
      S_W_DATA: begin
        if (axi.wvalid) begin
          mem_we  = !werr_b_q;
          widx_d  = widx_q + idx_t'(1);
          wbeat_d = wbeat_q + 8'd1;
          if (axi.wlast) begin
            w_state_d = S_W_RESP;
            if (wbeat_q != wlen_q) werr_l_d = 1'b1;
          end else if (wbeat_q == wlen_q) begin
            // overrun: drain until wlast
            werr_l_d = 1'b1;
          end
        end
      end
      S_W_RESP: begin
        if (axi.bready) w_state_d = S_W_IDLE;
      end
      default: w_state_d = S_W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    rid_d     = rid_q;
    ridx_d    = ridx_q;
    rlen_d    = rlen_q;
    rbeat_d   = rbeat_q;
    rerr_d    = rerr_q;
    mem_re    = 1'b0;
    unique case (r_state_q)
      S_R_IDLE: begin
        if (axi.arvalid) begin
          r_state_d = S_R_FETCH;
          rid_d     = axi.arid;
          ridx_d    = axi.araddr[IHI:ASZ];
          rlen_d    = axi.arlen;
          rbeat_d   = 8'd0;
          rerr_d    = bad_burst(axi.arburst,
                                axi.arsize);
        end
      end
      S_R_FETCH: begin
        mem_re    = 1'b1;
        ridx_d    = ridx_q + idx_t'(1);
        r_state_d = S_R_DATA;
      end
      S_R_DATA: begin
        if (axi.rready) begin
          if (rbeat_q == rlen_q) begin
            r_state_d = S_R_IDLE;
          end else begin
            // prefetch next word on each accept
            mem_re  = 1'b1;
            ridx_d  = ridx_q + idx_t'(1);
            rbeat_d = rbeat_q + 8'd1;
          end
        end
      end
      default: r_state_d = S_R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      w_state_q <= S_W_IDLE;
      wid_q     <= '0;
      widx_q    <= '0;
      wlen_q    <= '0;
      wbeat_q   <= '0;
      werr_b_q  <= 1'b0;
      werr_l_q  <= 1'b0;
      r_state_q <= S_R_IDLE;
      rid_q     <= '0;
      ridx_q    <= '0;
      rlen_q    <= '0;
      rbeat_q   <= '0;
      rerr_q    <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      wid_q     <= wid_d;
      widx_q    <= widx_d;
      wlen_q    <= wlen_d;
      wbeat_q   <= wbeat_d;
      werr_b_q  <= werr_b_d;
      werr_l_q  <= werr_l_d;
      r_state_q <= r_state_d;
      rid_q     <= rid_d;
      ridx_q    <= ridx_d;
      rlen_q    <= rlen_d;
      rbeat_q   <= rbeat_d;
      rerr_q    <= rerr_d;
    end
  end

  s_axi_mem_mem_dp #(
    .DW (DWIDTH),
    .AW (DEPTH_LOG)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .be    (axi.wstrb),
    .waddr (widx_q),
    .wdata (axi.wdata),
    .re    (mem_re),
    .raddr (ridx_q),
    .rdata (mem_rdata)
  );

  assign axi.awready = (w_state_q == S_W_IDLE);
  assign axi.wready  = (w_state_q == S_W_DATA);
  assign axi.bvalid  = (w_state_q == S_W_RESP);
  assign axi.bid     = wid_q;
  assign axi.bresp   =
    (axi.bvalid && (werr_b_q || werr_l_q)) ?
    SLVERR : OKAY;
  assign axi.buser   = '0;

  assign axi.arready = (r_state_q == S_R_IDLE);
  assign axi.rvalid  = (r_state_q == S_R_DATA);
  assign axi.rid     = rid_q;
  assign axi.rdata   = mem_rdata;
  assign axi.rlast   = axi.rvalid &&
                       (rbeat_q == rlen_q);
  assign axi.rresp   = (axi.rvalid && rerr_q) ?
                       SLVERR : OKAY;
  assign axi.ruser   = '0;

  logic unused_ok;
  assign unused_ok = ^{axi.awlock, axi.awcache,
    axi.awprot, axi.awqos, axi.awuser,
    axi.wuser, axi.arlock, axi.arcache,
    axi.arprot, axi.arqos, axi.aruser,
    axi.awaddr, axi.araddr};

endmodule
